// File: rtl/data_mem_ctrl.sv
// Data-memory responder for the memory stage. Loads return after a fixed
// latency with forwarding from a small posted-store buffer; buffered stores
// drain into the single-port array whenever the port is not taken by a request.
module data_mem_ctrl #(
    parameter int unsigned AW       = 4,
    parameter int unsigned DW       = 32,
    parameter int unsigned RD_LAT   = 2,
    parameter int unsigned WB_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_we,
    input  logic [AW-1:0]                   req_addr,
    input  logic [DW-1:0]                   req_wdata,
    output logic                            rsp_valid,
    output logic [DW-1:0]                   rsp_data,
    output logic [AW-1:0]                   rsp_addr,
    output logic [$clog2(WB_DEPTH+1)-1:0]   wb_count,
    output logic                            init_done
);

    localparam int unsigned CW       = $clog2(WB_DEPTH + 1);
    localparam int unsigned PW       = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int unsigned LW       = $clog2(RD_LAT + 1);
    localparam int unsigned NumWords = 1 << AW;

    typedef enum logic [1:0] {StInit, StIdle, StRdWait} state_e;

    // Control state and registered outputs
    state_e          state_q;
    logic [AW-1:0]   clr_cnt_q;
    logic [LW-1:0]   lat_q;
    logic [DW-1:0]   ld_data_q;
    logic [AW-1:0]   ld_addr_q;
    logic            rsp_valid_q;
    logic [DW-1:0]   rsp_data_q;
    logic [AW-1:0]   rsp_addr_q;
    logic            init_done_q;

    // Storage array
    logic [DW-1:0]   mem_q [NumWords];

    // Write buffer (circular FIFO)
    logic [AW-1:0]   wb_addr_q [WB_DEPTH];
    logic [DW-1:0]   wb_data_q [WB_DEPTH];
    logic [PW-1:0]   wb_head_q;
    logic [PW-1:0]   wb_tail_q;
    logic [CW-1:0]   wb_count_q;

    logic            wb_full;
    logic            handshake;
    logic            push;
    logic            load;
    logic            drain;
    logic            fwd_hit;
    logic [DW-1:0]   fwd_data;
    int              fwd_idx;
    logic [DW-1:0]   ld_data;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [DW-1:0]   mem_wdata;

    assign wb_full   = (wb_count_q == CW'(WB_DEPTH));
    assign req_ready = (state_q == StIdle) && !wb_full;
    assign handshake = req_valid && req_ready;
    assign push      = handshake && req_we;
    assign load      = handshake && !req_we;
    // The port is owned by the request on a handshake cycle, so drain only otherwise.
    assign drain     = (state_q != StInit) && (wb_count_q != '0) && !handshake;

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_addr  = rsp_addr_q;
    assign wb_count  = wb_count_q;
    assign init_done = init_done_q;

    // Youngest buffered store to the load address wins: scan oldest to youngest.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = 0;
        for (int i = 0; i < int'(WB_DEPTH); i++) begin
            fwd_idx = int'(wb_head_q) + i;
            if (fwd_idx >= int'(WB_DEPTH)) begin
                fwd_idx = fwd_idx - int'(WB_DEPTH);
            end
            if ((i < int'(wb_count_q)) && (wb_addr_q[fwd_idx[PW-1:0]] == req_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_data_q[fwd_idx[PW-1:0]];
            end
        end
    end

    assign ld_data = fwd_hit ? fwd_data : mem_q[req_addr];

    // Array write port: clear sequence during INIT, buffer drain otherwise.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        if (rst) begin
            if (state_q == StInit) begin
                mem_we = 1'b1;
            end else if (drain) begin
                mem_we    = 1'b1;
                mem_waddr = wb_addr_q[wb_head_q];
                mem_wdata = wb_data_q[wb_head_q];
            end
        end
    end

    // Array storage, no reset: contents are cleared by the INIT sequence.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Write-buffer payload, written at the tail on a store push.
    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr_q[wb_tail_q] <= req_addr;
            wb_data_q[wb_tail_q] <= req_wdata;
        end
    end

    // Write-buffer pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_head_q  <= '0;
            wb_tail_q  <= '0;
            wb_count_q <= '0;
        end else if (push) begin
            wb_tail_q  <= (wb_tail_q == PW'(WB_DEPTH - 1)) ? '0 : wb_tail_q + PW'(1);
            wb_count_q <= wb_count_q + CW'(1);
        end else if (drain) begin
            wb_head_q  <= (wb_head_q == PW'(WB_DEPTH - 1)) ? '0 : wb_head_q + PW'(1);
            wb_count_q <= wb_count_q - CW'(1);
        end
    end

    // Control FSM: clear sequence, load accept, fixed-latency response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StInit;
            clr_cnt_q   <= '0;
            lat_q       <= '0;
            ld_data_q   <= '0;
            ld_addr_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_addr_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StInit: begin
                    clr_cnt_q <= clr_cnt_q + AW'(1);
                    if (clr_cnt_q == '1) begin
                        init_done_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                StIdle: begin
                    if (load) begin
                        if (RD_LAT == 1) begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= ld_data;
                            rsp_addr_q  <= req_addr;
                        end else begin
                            ld_data_q <= ld_data;
                            ld_addr_q <= req_addr;
                            lat_q     <= LW'(1);
                            state_q   <= StRdWait;
                        end
                    end
                end
                StRdWait: begin
                    if (lat_q == LW'(RD_LAT - 1)) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= ld_data_q;
                        rsp_addr_q  <= ld_addr_q;
                        state_q     <= StIdle;
                    end else begin
                        lat_q <= lat_q + LW'(1);
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed requests with literal expectations, plus a
// cycle-by-cycle reference model built on a store queue and response timestamps.
module tb_data_mem_ctrl;

    localparam int AW       = 4;
    localparam int DW       = 32;
    localparam int RD_LAT   = 2;
    localparam int WB_DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rsp_addr;
    logic [1:0]    wb_count;
    logic          init_done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(
        .AW       (AW),
        .DW       (DW),
        .RD_LAT   (RD_LAT),
        .WB_DEPTH (WB_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_addr  (rsp_addr),
        .wb_count  (wb_count),
        .init_done (init_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic timeout(input string name, input int waited);
        n_checks++;
        $display("FAIL %s: no event after %0d cycles, event required", name, waited);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wb_t;

    wb_t           wbq[$];
    logic [DW-1:0] mem_m [16];
    bit            m_on = 1'b0;
    bit            m_init_done;
    int            m_init_left;
    int            cyc = 0;
    bit            pend_v;
    int            pend_due;
    logic [AW-1:0] pend_a;
    logic [DW-1:0] pend_d;
    logic [AW-1:0] last_a;
    logic [DW-1:0] last_d;

    always @(negedge clk) begin
        bit            busy;
        bit            e_ready;
        bit            e_rv;
        bit            hs;
        logic [DW-1:0] e_d;
        logic [AW-1:0] e_a;
        busy    = pend_v && (pend_due > cyc);
        e_ready = m_init_done && !busy && (wbq.size() < WB_DEPTH);
        e_rv    = pend_v && (pend_due == cyc);
        e_d     = e_rv ? pend_d : last_d;
        e_a     = e_rv ? pend_a : last_a;
        if (m_on) begin
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
            chk("rsp_data", rsp_data, e_d);
            chk("rsp_addr", 32'(rsp_addr), 32'(e_a));
            chk("wb_count", 32'(wb_count), 32'(wbq.size()));
            chk("init_done", 32'(init_done), 32'(m_init_done));
        end
        if (!rst) begin
            m_on        = 1'b1;
            m_init_done = 1'b0;
            m_init_left = 1 << AW;
            wbq.delete();
            pend_v      = 1'b0;
            last_a      = '0;
            last_d      = '0;
        end else if (m_on) begin
            hs = req_valid && e_ready;
            if (!m_init_done) begin
                m_init_left--;
                if (m_init_left == 0) begin
                    m_init_done = 1'b1;
                    foreach (mem_m[i]) mem_m[i] = '0;
                end
            end else begin
                if (e_rv) begin
                    last_d = pend_d;
                    last_a = pend_a;
                    pend_v = 1'b0;
                end
                if (hs && req_we) begin
                    wbq.push_back('{a: req_addr, d: req_wdata});
                end else if (hs) begin
                    pend_v   = 1'b1;
                    pend_due = cyc + RD_LAT;
                    pend_a   = req_addr;
                    pend_d   = mem_m[req_addr];
                    for (int i = 0; i < wbq.size(); i++) begin
                        if (wbq[i].a == req_addr) pend_d = wbq[i].d;
                    end
                end else if (wbq.size() > 0) begin
                    mem_m[wbq[0].a] = wbq[0].d;
                    void'(wbq.pop_front());
                end
            end
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        forever begin
            @(negedge clk);
            if (init_done) break;
            n++;
            if (n > 100) begin
                timeout("init_done", n);
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit hold, output int waits);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        waits     = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            waits++;
            if (waits > 50) begin
                timeout("accept", waits);
                break;
            end
            tick();
        end
        tick();
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [DW-1:0] d, output logic [AW-1:0] a,
                            output int lat, output logic rdy);
        lat = 1;
        d   = '0;
        a   = '0;
        rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                d   = rsp_data;
                a   = rsp_addr;
                rdy = req_ready;
                break;
            end
            lat++;
            if (lat > 20) begin
                timeout("rsp_valid", lat);
                break;
            end
            tick();
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, finish required", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int            n;
        int            w0, w1, w2;
        int            lat;
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        logic          rdy;
        logic [AW-1:0] t4_addr [3];
        logic [DW-1:0] t4_data [3];
        t4_addr = '{4'd1, 4'd2, 4'd4};
        t4_data = '{32'h0000_00A1, 32'h0000_00B2, 32'h0000_00C4};

        rst       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Clear sequence, then a load of a cleared word.
        wait_init(n);
        chk("init_cycles", 32'(n), 32'd16);
        send(1'b0, 4'd5, '0, 1'b0, w0);
        wait_rsp(d, a, lat, rdy);
        chk("t1_lat", 32'(lat), 32'd2);
        chk("t1_data", d, 32'h0);
        chk("t1_addr", 32'(a), 32'd5);

        // Store then immediate load forwards from the buffer.
        send(1'b1, 4'd3, 32'hDEAD_BEEF, 1'b1, w0);
        send(1'b0, 4'd3, '0, 1'b0, w1);
        chk("t2_wait", 32'(w1), 32'd0);
        wait_rsp(d, a, lat, rdy);
        chk("t2_lat", 32'(lat), 32'd2);
        chk("t2_data", d, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("t2_wb_count", 32'(wb_count), 32'd0);
        tick();

        // Two stores to one address fill the buffer; load sees the youngest.
        send(1'b1, 4'd7, 32'h11, 1'b1, w0);
        send(1'b1, 4'd7, 32'h22, 1'b1, w1);
        send(1'b0, 4'd7, '0, 1'b0, w2);
        chk("t3_wait", 32'(w2), 32'd1);
        wait_rsp(d, a, lat, rdy);
        chk("t3_data", d, 32'h22);
        chk("t3_addr", 32'(a), 32'd7);

        // Three stores with valid held: accepted on cycles 0, 1, 3.
        send(1'b1, t4_addr[0], t4_data[0], 1'b1, w0);
        send(1'b1, t4_addr[1], t4_data[1], 1'b1, w1);
        send(1'b1, t4_addr[2], t4_data[2], 1'b0, w2);
        chk("t4_wait0", 32'(w0), 32'd0);
        chk("t4_wait1", 32'(w1), 32'd0);
        chk("t4_wait2", 32'(w2), 32'd1);
        @(negedge clk);
        chk("t4_wb_count", 32'(wb_count), 32'd2);
        tick();
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            send(1'b0, t4_addr[i], '0, 1'b0, w0);
            wait_rsp(d, a, lat, rdy);
            chk("t4_load", d, t4_data[i]);
        end

        // Second request accepted in the same cycle the first response pulses.
        send(1'b0, 4'd3, '0, 1'b1, w0);
        req_addr = 4'd7;
        wait_rsp(d, a, lat, rdy);
        req_valid = 1'b0;
        chk("t6_lat", 32'(lat), 32'd2);
        chk("t6_rdy_at_rsp", 32'(rdy), 32'd1);
        chk("t6_data0", d, 32'hDEAD_BEEF);
        wait_rsp(d, a, lat, rdy);
        chk("t6_lat1", 32'(lat), 32'd2);
        chk("t6_data1", d, 32'h22);
        chk("t6_addr1", 32'(a), 32'd7);

        // Reset with a load in flight and a store buffered.
        send(1'b1, 4'd9, 32'h55, 1'b1, w0);
        send(1'b0, 4'd9, '0, 1'b0, w1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        wait_init(n);
        chk("t5_init_cycles", 32'(n), 32'd16);
        send(1'b0, 4'd9, '0, 1'b0, w0);
        wait_rsp(d, a, lat, rdy);
        chk("t5_data", d, 32'h0);
        chk("t5_addr", 32'(a), 32'd9);

        repeat (4) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Data-memory responder serving the memory stage's load/store requests over a valid/ready handshake.
- Contents: 2^AW words of DW bits in a single-port array, cleared by a sequencer after reset.
- Stores are posted into a small write buffer and drained to the array in idle port cycles. Loads return after a fixed latency, with forwarding from buffered stores.
- Sits between mem_stage and the data storage; the response feeds LMD.

Parameters:
AW, 4, address width; the array holds 2^AW words
DW, 32, data width
RD_LAT, 2, cycles from load accept to rsp_valid; must be >= 1
WB_DEPTH, 2, write-buffer entries; must be >= 1

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_addr  in  AW  word address
req_wdata  in  DW  store data
rsp_valid  out  1  one-cycle pulse: load data valid
rsp_data  out  DW  load data
rsp_addr  out  AW  address of the returned load
wb_count  out  $clog2(WB_DEPTH+1)  buffered stores not yet in the array
init_done  out  1  clear sequence complete

Behaviour:
- Reset (rst low at a clock edge):
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_addr=0, wb_count=0, init_done=0.
  - Write buffer is emptied; pending stores are discarded.
  - Any in-flight load is cancelled and produces no rsp_valid.
  - FSM enters INIT with the clear counter at 0.
- FSM states: INIT, IDLE, RD_WAIT.
  - INIT: writes 0 to array[cnt] each cycle, cnt 0..2^AW-1. After the last word: init_done=1 and FSM goes to IDLE. INIT lasts exactly 2^AW cycles (16 by default).
  - IDLE: handshake = req_valid & req_ready, with req_ready = (state==IDLE) & ~wb_full. req_ready does not depend on req_valid.
  - IDLE, store handshake: {addr, wdata} pushed to the write-buffer tail; FSM stays in IDLE. Back-to-back stores are allowed.
  - IDLE, load handshake: data is sampled in the accept cycle; FSM goes to RD_WAIT with a latency counter.
  - RD_WAIT: req_ready=0. At accept+RD_LAT, rsp_valid pulses for 1 cycle with rsp_data/rsp_addr, and FSM returns to IDLE in that same cycle, so req_ready may be high alongside rsp_valid.
  - rsp_data/rsp_addr hold their last values between pulses. There is no response backpressure.
- Load data source:
  - If any buffered entry matches req_addr, the youngest match is returned.
  - Otherwise the array word is returned.
  - A store accepted in the same cycle as the load is impossible (one request per cycle).
- Drain: in any non-INIT cycle with wb_count>0 and no handshake (the single port is busy on a handshake cycle), the head entry is written to the array and popped.
  - Drain also occurs during RD_WAIT.
  - Push and pop never coincide (push needs a handshake; drain needs none).
- wb_count increments on push and decrements on drain.
- Full: wb_count==WB_DEPTH. req_ready is low for both loads and stores until a drain occurs.
- Write buffer is a circular FIFO; head/tail pointers wrap modulo WB_DEPTH.
- Addresses wrap naturally within AW bits. No byte enables; full-word access only.

Test Plan:
- Release rst -> req_ready=0 for 16 cycles, init_done rises at cycle 16; load addr 5 accepted at T -> rsp_valid at T+2, rsp_data=0, rsp_addr=5.
- Store 0xDEADBEEF to addr 3, then load addr 3 on the next cycle (entry still buffered) -> rsp_data=0xDEADBEEF at accept+2; wb_count 1 then 0 after the drain during RD_WAIT.
- Stores to addr 7 of 0x11 then 0x22 back-to-back, then load 7 -> wb_count=2, req_ready=0 for one cycle (drain), load returns 0x22.
- Three back-to-back stores with req_valid held -> accepted on cycles 0, 1, 3; wb_count sequence 1, 2, 1, 2, then drains to 0 after req_valid drops; later loads return each value.
- Load accepted, then rst low the next cycle -> no rsp_valid pulse, wb_count=0, INIT repeats; a previously buffered store reads back 0.
- Load accepted at T with a second req_valid held high -> second request accepted at T+2, coincident with the first rsp_valid.
